// File: rtl/apb_master_arbiter.sv
// Round-robin front end that shares one APB master command port among NUM_REQ requesters.
// One transaction in flight at a time: IDLE -> ISSUE -> WAIT -> RESP, with a WAIT-state watchdog.
module apb_master_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                              PCLK,
  input  logic                              PRESET,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_strb,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              rsp_error,
  output logic                              transfer,
  output logic                              write_read,
  output logic [ADDR_WIDTH-1:0]             addr_in,
  output logic [DATA_WIDTH-1:0]             wdata_in,
  output logic [DATA_WIDTH/8-1:0]           strb_in,
  input  logic                              transfer_done,
  input  logic [DATA_WIDTH-1:0]             rdata_out,
  input  logic                              error,
  output logic [1:0]                        dbg_state_o,
  output logic [$clog2(NUM_REQ)-1:0]        dbg_rr_ptr_o
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]           grant_q, grant_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]           strb_q, strb_d;
  logic                    xfer_q, xfer_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [WDW-1:0]          wdog_q, wdog_d;
  logic [IW-1:0]           win_idx;
  logic                    any_valid;
  logic                    wd_expired;

  // Winner is the first valid requester at or after rr_ptr; lower k overrides, so rr_ptr ranks highest.
  always_comb begin
    int idx;
    idx       = 0;
    win_idx   = '0;
    any_valid = |req_valid;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) win_idx = IW'(idx);
    end
  end

  assign wd_expired = (TIMEOUT != 0) && (wdog_q == WD_LAST);

  // Handshake: a command is accepted in the cycle where req_valid[i] && req_ready[i]; ready is only
  // ever raised in IDLE, for the single round-robin winner, and requesters hold payload until then.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    xfer_d    = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    wdog_d    = wdog_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          req_ready[win_idx] = 1'b1;
          grant_d = win_idx;
          wr_d    = req_write[win_idx];
          addr_d  = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
          strb_d  = req_write[win_idx] ? req_strb[win_idx*SW +: SW] : '0;
          xfer_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (TIMEOUT != 0) wdog_d = wdog_q + 1'b1;
        // A completion in the same cycle as expiry still delivers the slave's result.
        if (transfer_done) begin
          rdata_d = wr_q ? '0 : rdata_out;
          err_d   = error;
          state_d = S_RESP;
        end else if (wd_expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid[grant_q] = 1'b1;
        rr_ptr_d = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        wdog_d   = '0;
        wr_d     = 1'b0;
        addr_d   = '0;
        wdata_d  = '0;
        strb_d   = '0;
        rdata_d  = '0;
        err_d    = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (PRESET) req_ready = '0;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      xfer_q   <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      xfer_q   <= xfer_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
    end
  end

  assign transfer     = xfer_q;
  assign write_read   = wr_q;
  assign addr_in      = addr_q;
  assign wdata_in     = wdata_q;
  assign strb_in      = strb_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_error    = err_q;
  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule
